// File: rtl/sprite_pkg.sv
// Shared sprite pipeline definitions: scheduler FSM encoding, object record width, hit test.
package sprite_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SCAN = 2'd1,
    ST_DONE = 2'd2
  } sched_state_e;

  // Object record is packed as {vis, y, x}.
  function automatic int obj_rec_w(input int cordw);
    return 2 * cordw + 1;
  endfunction

  // Line-overlap test on sign-extended coordinates; one spare bit keeps the difference exact.
  function automatic logic hit_test(input logic               vis,
                                    input logic signed [31:0] target,
                                    input logic signed [31:0] y,
                                    input logic        [31:0] height);
    logic signed [32:0] d;
    d = {target[31], target} - {y[31], y};
    return vis && !d[32] && (d < $signed({1'b0, height}));
  endfunction

endpackage

// File: rtl/sprite_obj_table.sv
// Object table: N_OBJ records, one write port, one registered read port, resets to invisible at (0,0).
module sprite_obj_table #(
  parameter  int N_OBJ = 16,
  parameter  int W     = 21,
  localparam int IW    = $clog2(N_OBJ)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          wr_en_i,
  input  logic [IW-1:0] wr_idx_i,
  input  logic [W-1:0]  wr_data_i,
  input  logic          rd_en_i,
  input  logic [IW-1:0] rd_idx_i,
  output logic [W-1:0]  rd_data_o
);

  logic [W-1:0] mem_q [N_OBJ];
  logic [W-1:0] rd_data_q;

  // A read in the same cycle as a write to that entry returns the old record.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < N_OBJ; i++) mem_q[i] <= '0;
      rd_data_q <= '0;
    end else begin
      if (wr_en_i) mem_q[wr_idx_i] <= wr_data_i;
      if (rd_en_i) rd_data_q <= mem_q[rd_idx_i];
    end
  end

  assign rd_data_o = rd_data_q;

endmodule

// File: rtl/sprite_line_sched.sv
// Per-scanline sprite scheduler: scans the object table for the next line, commits slots on each line pulse.
// Optional SPRITE_SCHED_OVF_CNT_EN adds a saturating count of committed overflow lines.
module sprite_line_sched
  import sprite_pkg::*;
#(
  parameter  int CORDW      = 10,
  parameter  int V_RES      = 600,
  parameter  int N_OBJ      = 16,
  parameter  int N_SLOT     = 4,
  parameter  int SPR_HEIGHT = 8,
  parameter  int SPR_SCALE  = 0,
  localparam int IW         = $clog2(N_OBJ)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     line,
  input  logic signed [CORDW-1:0]  sy,
  input  logic                     wr_en,
  input  logic [IW-1:0]            wr_idx,
  input  logic signed [CORDW-1:0]  wr_x,
  input  logic signed [CORDW-1:0]  wr_y,
  input  logic                     wr_vis,
  output logic [N_SLOT-1:0]        slot_en,
  output logic [N_SLOT*CORDW-1:0]  slot_x,
  output logic [N_SLOT*CORDW-1:0]  slot_y,
  output logic [N_SLOT*IW-1:0]     slot_idx,
  output logic                     busy,
  output logic                     ovf,
  output logic                     late
`ifdef SPRITE_SCHED_OVF_CNT_EN
  ,
  output logic [7:0]               ovf_cnt
`endif
);

  localparam int RW    = obj_rec_w(CORDW);
  localparam int CW    = $clog2(N_SLOT + 1);
  localparam int OBJ_H = SPR_HEIGHT << SPR_SCALE;

  sched_state_e state_q;
  logic [IW-1:0]            ptr_q;
  logic                     issue_q;
  logic                     valid_q;
  logic [IW-1:0]            vidx_q;
  logic signed [CORDW-1:0]  target_q, target_d;
  logic                     busy_q;
  logic                     late_q;
  logic [CW-1:0]            fill_q;
  logic [N_SLOT-1:0]        sh_en_q;
  logic [N_SLOT*CORDW-1:0]  sh_x_q, sh_y_q;
  logic [N_SLOT*IW-1:0]     sh_idx_q;
  logic                     sh_ovf_q;
  logic [N_SLOT-1:0]        slot_en_q;
  logic [N_SLOT*CORDW-1:0]  slot_x_q, slot_y_q;
  logic [N_SLOT*IW-1:0]     slot_idx_q;
  logic                     ovf_q;
`ifdef SPRITE_SCHED_OVF_CNT_EN
  logic [7:0]               ovf_cnt_q;
`endif

  logic                     rd_en_s;
  logic [RW-1:0]            rd_data_s;
  logic signed [CORDW-1:0]  rd_x_s, rd_y_s;
  logic                     rd_vis_s;
  logic                     hit_s;

  assign rd_en_s = (state_q == ST_SCAN) && issue_q && !line;

  sprite_obj_table #(
    .N_OBJ (N_OBJ),
    .W     (RW)
  ) u_table (
    .clk       (clk),
    .rst       (rst),
    .wr_en_i   (wr_en),
    .wr_idx_i  (wr_idx),
    .wr_data_i ({wr_vis, wr_y, wr_x}),
    .rd_en_i   (rd_en_s),
    .rd_idx_i  (ptr_q),
    .rd_data_o (rd_data_s)
  );

  assign rd_x_s   = rd_data_s[CORDW-1:0];
  assign rd_y_s   = rd_data_s[2*CORDW-1:CORDW];
  assign rd_vis_s = rd_data_s[2*CORDW];

  // Target line for the coming scan, wrapping at the bottom of the frame.
  always_comb begin
    target_d = '0;
    if (sy == CORDW'(V_RES - 1)) begin
      target_d = '0;
    end else begin
      target_d = sy + CORDW'(1);
    end
  end

  // Overlap test of the record returned by the previous cycle's read.
  always_comb begin
    hit_s = hit_test(rd_vis_s,
                     {{(32-CORDW){target_q[CORDW-1]}}, target_q},
                     {{(32-CORDW){rd_y_s[CORDW-1]}}, rd_y_s},
                     32'(OBJ_H));
  end

  // Scan FSM, slot allocator into the shadow set, and commit of the shadow on each line pulse.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= ST_IDLE;
      ptr_q      <= '0;
      issue_q    <= 1'b0;
      valid_q    <= 1'b0;
      vidx_q     <= '0;
      target_q   <= '0;
      busy_q     <= 1'b0;
      late_q     <= 1'b0;
      fill_q     <= '0;
      sh_en_q    <= '0;
      sh_x_q     <= '0;
      sh_y_q     <= '0;
      sh_idx_q   <= '0;
      sh_ovf_q   <= 1'b0;
      slot_en_q  <= '0;
      slot_x_q   <= '0;
      slot_y_q   <= '0;
      slot_idx_q <= '0;
      ovf_q      <= 1'b0;
`ifdef SPRITE_SCHED_OVF_CNT_EN
      ovf_cnt_q  <= 8'd0;
`endif
    end else if (line) begin
      slot_en_q  <= sh_en_q;
      slot_x_q   <= sh_x_q;
      slot_y_q   <= sh_y_q;
      slot_idx_q <= sh_idx_q;
      ovf_q      <= sh_ovf_q;
`ifdef SPRITE_SCHED_OVF_CNT_EN
      if (sh_ovf_q && (ovf_cnt_q != 8'd255)) begin
        ovf_cnt_q <= ovf_cnt_q + 8'd1;
      end
`endif
      if (state_q == ST_SCAN) late_q <= 1'b1;
      fill_q   <= '0;
      sh_en_q  <= '0;
      sh_x_q   <= '0;
      sh_y_q   <= '0;
      sh_idx_q <= '0;
      sh_ovf_q <= 1'b0;
      target_q <= target_d;
      ptr_q    <= '0;
      issue_q  <= 1'b1;
      valid_q  <= 1'b0;
      busy_q   <= 1'b1;
      state_q  <= ST_SCAN;
    end else begin
      case (state_q)
        ST_SCAN: begin
          valid_q <= issue_q;
          vidx_q  <= ptr_q;
          if (issue_q) begin
            if (ptr_q == IW'(N_OBJ - 1)) begin
              issue_q <= 1'b0;
            end else begin
              ptr_q <= ptr_q + IW'(1);
            end
          end
          if (valid_q) begin
            if (hit_s) begin
              if (fill_q < CW'(N_SLOT)) begin
                for (int k = 0; k < N_SLOT; k++) begin
                  if (fill_q == CW'(k)) begin
                    sh_en_q[k]                <= 1'b1;
                    sh_x_q[k*CORDW +: CORDW]  <= rd_x_s;
                    sh_y_q[k*CORDW +: CORDW]  <= rd_y_s;
                    sh_idx_q[k*IW +: IW]      <= vidx_q;
                  end
                end
                fill_q <= fill_q + CW'(1);
              end else begin
                sh_ovf_q <= 1'b1;
              end
            end
            if (vidx_q == IW'(N_OBJ - 1)) begin
              busy_q  <= 1'b0;
              state_q <= ST_DONE;
            end
          end
        end
        default: begin
          valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign slot_en  = slot_en_q;
  assign slot_x   = slot_x_q;
  assign slot_y   = slot_y_q;
  assign slot_idx = slot_idx_q;
  assign busy     = busy_q;
  assign ovf      = ovf_q;
  assign late     = late_q;
`ifdef SPRITE_SCHED_OVF_CNT_EN
  assign ovf_cnt  = ovf_cnt_q;
`endif

endmodule

// File: tb/tb_sprite_line_sched.sv
// Directed self-checking bench for sprite_line_sched with default parameters.
module tb_sprite_line_sched;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        line = 1'b0;
  logic [9:0]  sy = 10'd0;
  logic        wr_en = 1'b0;
  logic [3:0]  wr_idx = 4'd0;
  logic [9:0]  wr_x = 10'd0;
  logic [9:0]  wr_y = 10'd0;
  logic        wr_vis = 1'b0;
  logic [3:0]  slot_en;
  logic [39:0] slot_x, slot_y;
  logic [15:0] slot_idx;
  logic        busy, ovf, late;
`ifdef SPRITE_SCHED_OVF_CNT_EN
  logic [7:0]  ovf_cnt;
`endif

  int n_checks = 0;
  int n_errors = 0;

  sprite_line_sched dut (
    .clk      (clk),
    .rst      (rst),
    .line     (line),
    .sy       (sy),
    .wr_en    (wr_en),
    .wr_idx   (wr_idx),
    .wr_x     (wr_x),
    .wr_y     (wr_y),
    .wr_vis   (wr_vis),
    .slot_en  (slot_en),
    .slot_x   (slot_x),
    .slot_y   (slot_y),
    .slot_idx (slot_idx),
    .busy     (busy),
    .ovf      (ovf),
    .late     (late)
`ifdef SPRITE_SCHED_OVF_CNT_EN
    ,
    .ovf_cnt  (ovf_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wr_obj(input logic [3:0] idx, input logic [9:0] x, input logic [9:0] y,
                        input logic vis);
    wr_en = 1'b1; wr_idx = idx; wr_x = x; wr_y = y; wr_vis = vis;
    tick();
    wr_en = 1'b0;
  endtask

  task automatic pulse_line(input logic [9:0] s);
    line = 1'b1; sy = s;
    tick();
    line = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int c = 0;
    while (busy === 1'b1 && c < 50) begin
      tick();
      c++;
    end
    chk(tag, 64'(c < 50), 64'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int bc;
    #1;
    chk("rst_en", 64'(slot_en), 64'h0);
    chk("rst_busy", 64'(busy), 64'h0);
    chk("rst_late", 64'(late), 64'h0);
    tick(); tick();
    rst = 1'b1;
    tick();

    // Single sprite, height boundary on both sides, busy length
    wr_obj(4'd0, 10'd100, 10'd20, 1'b1);
    pulse_line(10'd19);
    chk("busy_start", 64'(busy), 64'h1);
    bc = 0;
    while (busy === 1'b1 && bc < 50) begin
      bc++;
      tick();
    end
    chk("busy_len", 64'(bc), 64'd17);
    pulse_line(10'd27);
    chk("t2_en", 64'(slot_en), 64'h1);
    chk("t2_x", 64'(slot_x), 64'd100);
    chk("t2_y", 64'(slot_y), 64'd20);
    chk("t2_idx", 64'(slot_idx), 64'h0);
    chk("t2_ovf", 64'(ovf), 64'h0);
    wait_done("t2_wait1");
    pulse_line(10'd26);
    chk("t2_miss_en", 64'(slot_en), 64'h0);
    chk("t2_miss_x", 64'(slot_x), 64'h0);
    wait_done("t2_wait2");
    pulse_line(10'd26);
    chk("t2_edge_en", 64'(slot_en), 64'h1);
    wait_done("t2_wait3");

    // Overflow: six hits, four slots
    for (int k = 0; k < 6; k++) wr_obj(4'(k), 10'(10 * k + 1), 10'd50, 1'b1);
    pulse_line(10'd49);
    wait_done("t3_wait1");
    pulse_line(10'd200);
    chk("t3_en", 64'(slot_en), 64'hF);
    chk("t3_idx", 64'(slot_idx), 64'h3210);
    chk("t3_x", 64'(slot_x), 64'({10'd31, 10'd21, 10'd11, 10'd1}));
    chk("t3_ovf", 64'(ovf), 64'h1);
    wait_done("t3_wait2");
    pulse_line(10'd200);
    chk("t3_clr_en", 64'(slot_en), 64'h0);
    chk("t3_clr_ovf", 64'(ovf), 64'h0);
    wait_done("t3_wait3");

    // Frame wrap and bottom line
    for (int k = 1; k < 6; k++) wr_obj(4'(k), 10'd0, 10'd0, 1'b0);
    wr_obj(4'd0, 10'd5, 10'h3FD, 1'b1);
    pulse_line(10'd599);
    wait_done("t4_wait1");
    pulse_line(10'd597);
    chk("t4_wrap_en", 64'(slot_en), 64'h1);
    chk("t4_wrap_y", 64'(slot_y), 64'h3FD);
    chk("t4_wrap_x", 64'(slot_x), 64'd5);
    wait_done("t4_wait2");
    wr_obj(4'd0, 10'd5, 10'h3FD, 1'b0);
    wr_obj(4'd2, 10'd7, 10'd599, 1'b1);
    pulse_line(10'd598);
    chk("t4_598_en", 64'(slot_en), 64'h0);
    wait_done("t4_wait3");
    pulse_line(10'd0);
    chk("t4_bot_en", 64'(slot_en), 64'h1);
    chk("t4_bot_idx", 64'(slot_idx), 64'h2);
    chk("t4_bot_y", 64'(slot_y), 64'd599);
    wait_done("t4_wait4");

    // Write racing the scan read of the same entry
    wr_obj(4'd2, 10'd7, 10'd599, 1'b0);
    pulse_line(10'd99);
    tick(); tick(); tick();
    wr_obj(4'd3, 10'd40, 10'd100, 1'b1);
    wait_done("t6_wait1");
    pulse_line(10'd99);
    chk("t6_old_en", 64'(slot_en), 64'h0);
    wait_done("t6_wait2");
    pulse_line(10'd0);
    chk("t6_new_en", 64'(slot_en), 64'h1);
    chk("t6_new_idx", 64'(slot_idx), 64'h3);
    chk("t6_new_x", 64'(slot_x), 64'd40);
    chk("t6_late", 64'(late), 64'h0);
    wait_done("t6_wait3");

    // Line pulse six cycles into a scan
    wr_obj(4'd1, 10'd9, 10'd100, 1'b1);
    pulse_line(10'd99);
    tick(); tick(); tick(); tick(); tick();
    chk("t5_late_pre", 64'(late), 64'h0);
    pulse_line(10'd0);
    chk("t5_part_en", 64'(slot_en), 64'h3);
    chk("t5_part_idx", 64'(slot_idx), 64'h0031);
    chk("t5_part_x", 64'(slot_x), 64'({10'd40, 10'd9}));
    chk("t5_late", 64'(late), 64'h1);
    wait_done("t5_wait1");
    pulse_line(10'd99);
    chk("t5_next_en", 64'(slot_en), 64'h0);
    chk("t5_late_hold", 64'(late), 64'h1);
    wait_done("t5_wait2");
    pulse_line(10'd99);
    chk("t5_full_en", 64'(slot_en), 64'h3);

    // Asynchronous reset in the middle of a scan
    tick(); tick(); tick(); tick();
    chk("t1_busy_pre", 64'(busy), 64'h1);
    rst = 1'b0;
    #1;
    chk("t1_en", 64'(slot_en), 64'h0);
    chk("t1_x", 64'(slot_x), 64'h0);
    chk("t1_busy", 64'(busy), 64'h0);
    chk("t1_late", 64'(late), 64'h0);
    tick();
    rst = 1'b1;
    tick();
    chk("t1_idle_busy", 64'(busy), 64'h0);
    wr_obj(4'd0, 10'd100, 10'd20, 1'b1);
    pulse_line(10'd19);
    wait_done("t1_wait1");
    pulse_line(10'd0);
    chk("t1_re_en", 64'(slot_en), 64'h1);
    chk("t1_re_idx", 64'(slot_idx), 64'h0);
    chk("t1_re_late", 64'(late), 64'h0);
    wait_done("t1_wait2");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
